// File: rtl/rvc_asap_pkg.sv
// rtl/rvc_asap_pkg.sv - shared types and decode helpers for the rvc_asap core family
package rvc_asap_pkg;

    typedef enum logic [2:0] {RESET, FETCH, EXEC, MEM, HALT} t_mc_state;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_ALUI   = 7'b0010011,
        OP_ALU    = 7'b0110011,
        OP_FENCE  = 7'b0001111,
        OP_SYSTEM = 7'b1110011
    } t_opcode;

    // Encoded to match funct3 of the branch instructions.
    typedef enum logic [2:0] {
        BR_EQ = 3'b000, BR_NE = 3'b001, BR_NONE = 3'b010,
        BR_LT = 3'b100, BR_GE = 3'b101, BR_LTU = 3'b110, BR_GEU = 3'b111
    } t_branch_type;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} t_immediate;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS2, ALU_MUL
    } t_alu_op;

    function automatic logic [31:0] f_imm(input t_immediate sel, input logic [31:7] ir);
        case (sel)
            IMM_S:   f_imm = {{21{ir[31]}}, ir[30:25], ir[11:7]};
            IMM_B:   f_imm = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
            IMM_U:   f_imm = {ir[31:12], 12'b0};
            IMM_J:   f_imm = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
            default: f_imm = {{21{ir[31]}}, ir[30:20]};
        endcase
    endfunction

    function automatic t_alu_op f_alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  f_alu_op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  f_alu_op = ALU_SLL;
            3'b010:  f_alu_op = ALU_SLT;
            3'b011:  f_alu_op = ALU_SLTU;
            3'b100:  f_alu_op = ALU_XOR;
            3'b101:  f_alu_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  f_alu_op = ALU_OR;
            default: f_alu_op = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/rvc_asap_alu.sv
// rtl/rvc_asap_alu.sv - combinational ALU and branch compare; MUL built only with RVC_ASAP_MC_MUL_EN
module rvc_asap_alu
    import rvc_asap_pkg::*;
(
    input  logic [31:0]  AluIn1,
    input  logic [31:0]  AluIn2,
    input  t_alu_op      CtrlAluOp,
    input  t_branch_type CtrlBranchOp,
    output logic [31:0]  AluOut,
    output logic         BranchTaken
);

    always_comb begin
        case (CtrlAluOp)
            ALU_ADD:   AluOut = AluIn1 + AluIn2;
            ALU_SUB:   AluOut = AluIn1 - AluIn2;
            ALU_SLL:   AluOut = AluIn1 << AluIn2[4:0];
            ALU_SLT:   AluOut = {31'b0, $signed(AluIn1) < $signed(AluIn2)};
            ALU_SLTU:  AluOut = {31'b0, AluIn1 < AluIn2};
            ALU_XOR:   AluOut = AluIn1 ^ AluIn2;
            ALU_SRL:   AluOut = AluIn1 >> AluIn2[4:0];
            ALU_SRA:   AluOut = $signed(AluIn1) >>> AluIn2[4:0];
            ALU_OR:    AluOut = AluIn1 | AluIn2;
            ALU_AND:   AluOut = AluIn1 & AluIn2;
            ALU_PASS2: AluOut = AluIn2;
`ifdef RVC_ASAP_MC_MUL_EN
            ALU_MUL:   AluOut = AluIn1 * AluIn2;
`endif
            default:   AluOut = 32'b0;
        endcase
    end

    always_comb begin
        case (CtrlBranchOp)
            BR_EQ:   BranchTaken = (AluIn1 == AluIn2);
            BR_NE:   BranchTaken = (AluIn1 != AluIn2);
            BR_LT:   BranchTaken = ($signed(AluIn1) < $signed(AluIn2));
            BR_GE:   BranchTaken = ($signed(AluIn1) >= $signed(AluIn2));
            BR_LTU:  BranchTaken = (AluIn1 < AluIn2);
            BR_GEU:  BranchTaken = (AluIn1 >= AluIn2);
            default: BranchTaken = 1'b0;
        endcase
    end

endmodule

// File: rtl/rvc_asap_mc.sv
// rtl/rvc_asap_mc.sv - multi-cycle RV32I/RV32E core with valid/ready memory ports
// RVC_ASAP_MC_MUL_EN adds the MUL instruction.
module rvc_asap_mc
    import rvc_asap_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          NUM_REGS = 32
) (
    input  logic        Clock,
    input  logic        Rst,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemReady,
    input  logic [31:0] ImemRdData,
    output logic        DmemReq,
    output logic        DmemWrEn,
    output logic [31:0] DmemAddr,
    output logic [3:0]  DmemByteEn,
    output logic [31:0] DmemWrData,
    input  logic        DmemReady,
    input  logic [31:0] DmemRdData,
    output logic        Halt,
    output logic        Fault
);

    localparam int LP_AW = (NUM_REGS == 16) ? 4 : 5;

    if (NUM_REGS != 32 && NUM_REGS != 16) begin : g_bad_num_regs
        $error("rvc_asap_mc: NUM_REGS must be 16 or 32");
    end

    t_mc_state    r_state, w_next_state;
    logic [31:0]  r_pc, r_ir, r_mem_addr, r_mem_wdata;
    logic [3:0]   r_mem_be;
    logic         r_mem_we, r_halt, r_fault;
    logic [31:0]  r_regs [NUM_REGS];

    logic [6:0]   w_opcode, w_f7;
    logic [2:0]   w_f3;
    logic [4:0]   w_rd, w_rs1, w_rs2;
    logic [31:0]  w_rs1_val, w_rs2_val, w_imm, w_alu_in1, w_alu_in2, w_alu_out;
    logic [31:0]  w_pc_plus4, w_pc_imm, w_next_pc, w_rd_data, w_ld_word, w_ld_data;
    logic [3:0]   w_be;
    t_alu_op      w_alu_op;
    t_branch_type w_br;
    t_immediate   w_imm_sel;
    logic         w_in1_pc, w_in2_imm, w_wr_rd, w_use_rs1, w_use_rs2;
    logic         w_illegal, w_is_mem, w_is_sys, w_misalign, w_taken, w_stop;

    assign w_opcode   = r_ir[6:0];
    assign w_rd       = r_ir[11:7];
    assign w_f3       = r_ir[14:12];
    assign w_rs1      = r_ir[19:15];
    assign w_rs2      = r_ir[24:20];
    assign w_f7       = r_ir[31:25];
    assign w_rs1_val  = r_regs[w_rs1[LP_AW-1:0]];
    assign w_rs2_val  = r_regs[w_rs2[LP_AW-1:0]];
    assign w_imm      = f_imm(w_imm_sel, r_ir[31:7]);
    assign w_alu_in1  = w_in1_pc ? r_pc : w_rs1_val;
    assign w_alu_in2  = w_in2_imm ? w_imm : w_rs2_val;
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_pc_imm   = r_pc + w_imm;

    rvc_asap_alu u_alu (
        .AluIn1       (w_alu_in1),
        .AluIn2       (w_alu_in2),
        .CtrlAluOp    (w_alu_op),
        .CtrlBranchOp (w_br),
        .AluOut       (w_alu_out),
        .BranchTaken  (w_taken)
    );

    always_comb begin
        w_alu_op  = ALU_ADD;
        w_br      = BR_NONE;
        w_imm_sel = IMM_I;
        w_in1_pc  = 1'b0;
        w_in2_imm = 1'b1;
        w_wr_rd   = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_illegal = 1'b0;
        w_is_mem  = 1'b0;
        w_is_sys  = 1'b0;
        case (w_opcode)
            OP_LUI:   begin w_alu_op = ALU_PASS2; w_imm_sel = IMM_U; w_wr_rd = 1'b1; end
            OP_AUIPC: begin w_in1_pc = 1'b1; w_imm_sel = IMM_U; w_wr_rd = 1'b1; end
            OP_JAL:   begin w_imm_sel = IMM_J; w_wr_rd = 1'b1; end
            OP_JALR:  begin w_use_rs1 = 1'b1; w_wr_rd = 1'b1; w_illegal = (w_f3 != 3'b000); end
            OP_BRANCH: begin
                w_imm_sel = IMM_B;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_in2_imm = 1'b0;
                w_br      = t_branch_type'(w_f3);
                w_illegal = (w_f3[2:1] == 2'b01);
            end
            OP_LOAD: begin
                w_use_rs1 = 1'b1;
                w_wr_rd   = 1'b1;
                w_is_mem  = 1'b1;
                w_illegal = (w_f3 == 3'b011) || (w_f3[2:1] == 2'b11);
            end
            OP_STORE: begin
                w_imm_sel = IMM_S;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_is_mem  = 1'b1;
                w_illegal = w_f3[2] || (w_f3[1:0] == 2'b11);
            end
            OP_ALUI: begin
                w_use_rs1 = 1'b1;
                w_wr_rd   = 1'b1;
                // Only shifts carry funct7; an ADDI immediate with bit 30 set is still an add.
                w_alu_op  = f_alu_op(w_f3, w_f7[5] && w_f3 == 3'b101);
                w_illegal = (w_f3 == 3'b001 && w_f7 != 7'b0) ||
                            (w_f3 == 3'b101 && w_f7 != 7'b0 && w_f7 != 7'b0100000);
            end
            OP_ALU: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_wr_rd   = 1'b1;
                w_in2_imm = 1'b0;
                w_alu_op  = f_alu_op(w_f3, w_f7[5]);
                w_illegal = !(w_f7 == 7'b0 ||
                              (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101)));
`ifdef RVC_ASAP_MC_MUL_EN
                if (w_f7 == 7'b0000001 && w_f3 == 3'b000) begin
                    w_alu_op  = ALU_MUL;
                    w_illegal = 1'b0;
                end
`endif
            end
            OP_FENCE:  ;
            OP_SYSTEM: w_is_sys = 1'b1;
            default:   w_illegal = 1'b1;
        endcase
        if (NUM_REGS == 16 && ((w_use_rs1 && w_rs1[4]) || (w_use_rs2 && w_rs2[4]) ||
                               (w_wr_rd && w_rd[4])))
            w_illegal = 1'b1;
    end

    always_comb begin
        w_next_pc = w_pc_plus4;
        w_rd_data = w_alu_out;
        case (w_opcode)
            OP_JAL:    begin w_next_pc = w_pc_imm; w_rd_data = w_pc_plus4; end
            OP_JALR:   begin w_next_pc = {w_alu_out[31:1], 1'b0}; w_rd_data = w_pc_plus4; end
            OP_BRANCH: if (w_taken) w_next_pc = w_pc_imm;
            default:   ;
        endcase
    end

    always_comb begin
        case (w_f3[1:0])
            2'b00:   w_be = 4'b0001 << w_alu_out[1:0];
            2'b01:   w_be = 4'b0011 << w_alu_out[1:0];
            default: w_be = 4'b1111;
        endcase
    end

    assign w_misalign = w_is_mem && ((w_f3[1:0] == 2'b01 && w_alu_out[0]) ||
                                     (w_f3[1:0] == 2'b10 && w_alu_out[1:0] != 2'b00));
    assign w_stop     = w_illegal || w_misalign || w_is_sys;

    assign w_ld_word = DmemRdData >> {r_mem_addr[1:0], 3'b000};
    always_comb begin
        case (w_f3)
            3'b000:  w_ld_data = {{24{w_ld_word[7]}}, w_ld_word[7:0]};
            3'b001:  w_ld_data = {{16{w_ld_word[15]}}, w_ld_word[15:0]};
            3'b100:  w_ld_data = {24'b0, w_ld_word[7:0]};
            3'b101:  w_ld_data = {16'b0, w_ld_word[15:0]};
            default: w_ld_data = w_ld_word;
        endcase
    end

    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) r_state <= RESET;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RESET:   w_next_state = FETCH;
            FETCH:   if (ImemReady) w_next_state = EXEC;
            EXEC:    w_next_state = w_stop ? HALT : (w_is_mem ? MEM : FETCH);
            MEM:     if (DmemReady) w_next_state = FETCH;
            default: w_next_state = HALT;
        endcase
    end

    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            r_pc        <= RESET_PC;
            r_ir        <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            r_mem_we    <= 1'b0;
            r_halt      <= 1'b0;
            r_fault     <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            case (r_state)
                FETCH: if (ImemReady) r_ir <= ImemRdData;
                EXEC: begin
                    if (w_stop) begin
                        r_halt  <= 1'b1;
                        r_fault <= w_illegal || w_misalign;
                    end else if (w_is_mem) begin
                        r_mem_addr  <= w_alu_out;
                        r_mem_be    <= w_be;
                        r_mem_wdata <= w_rs2_val << {w_alu_out[1:0], 3'b000};
                        r_mem_we    <= (w_opcode == OP_STORE);
                    end else begin
                        r_pc <= w_next_pc;
                        if (w_wr_rd && w_rd[LP_AW-1:0] != '0) r_regs[w_rd[LP_AW-1:0]] <= w_rd_data;
                    end
                end
                MEM: if (DmemReady) begin
                    r_pc <= w_pc_plus4;
                    if (!r_mem_we && w_rd[LP_AW-1:0] != '0) r_regs[w_rd[LP_AW-1:0]] <= w_ld_data;
                end
                default: ;
            endcase
        end
    end

    assign ImemReq    = (r_state == FETCH);
    assign ImemAddr   = r_pc;
    assign DmemReq    = (r_state == MEM);
    assign DmemWrEn   = DmemReq && r_mem_we;
    assign DmemAddr   = {r_mem_addr[31:2], 2'b00};
    assign DmemByteEn = r_mem_be;
    assign DmemWrData = r_mem_wdata;
    assign Halt       = r_halt;
    assign Fault      = r_fault;

endmodule
